// File: rtl/dbus_arb_pkg.sv
// Shared types and helpers for the dbus round-robin arbiter.
// The timeout feature is enabled in dbus_rr_arb with DBUS_ARB_TIMEOUT_EN.
package dbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } arb_state_e;

   localparam logic [31:0] DBUS_ERR_DATA = 32'hDEAD_BEEF;

   // Up to 8 lanes; callers zero-pad narrower vectors.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after index `last`,
// wrapping at N. Shared with the ibus arbiter.
module rr_pick #(
   parameter int N  = 2,
   parameter int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  win,
   output logic          valid
);

   always_comb begin
      int   idx;
      logic found;
      win   = '0;
      idx   = 0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/dbus_rr_arb.sv
// Round-robin arbiter sharing one Wishbone-style dbus target between N requesters.
// Define DBUS_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending m_cyc
// OWN   | lane g forwarded to the target, waiting for s_ack
// TURN  | one dead cycle after completion so the requester can drop cyc
module dbus_rr_arb
   import dbus_arb_pkg::*;
#(
   parameter int N       = 2,
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic [N-1:0]    m_cyc,
   input  logic [N-1:0]    m_we,
   input  logic [N*AW-1:0] m_adr,
   input  logic [N*32-1:0] m_dat,
   input  logic [N*4-1:0]  m_sel,
   output logic [N-1:0]    m_ack,
   output logic [N*32-1:0] m_rdt,
   output logic            s_cyc,
   output logic            s_we,
   output logic [AW-1:0]   s_adr,
   output logic [31:0]     s_dat,
   output logic [3:0]      s_sel,
   input  logic            s_ack,
   input  logic [31:0]     s_rdt,
   output logic [N-1:0]    grant,
   output logic            busy
`ifdef DBUS_ARB_TIMEOUT_EN
  ,output logic            timeout
`endif
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;

   arb_state_e    state;
   logic [LW-1:0] last;
   logic [LW-1:0] g_idx;
   logic [LW-1:0] win_idx;
   logic [N-1:0]  win;
   logic          valid;
   logic          own;
   logic          to_hit;

   rr_pick #(.N(N), .LW(LW)) u_pick (
      .req   (m_cyc),
      .last  (last),
      .win   (win),
      .valid (valid)
   );

   always_comb begin
      logic [7:0] grant_w;
      logic [7:0] win_w;
      grant_w          = '0;
      win_w            = '0;
      grant_w[N-1:0]   = grant;
      win_w[N-1:0]     = win;
      g_idx            = LW'(onehot_to_idx(grant_w));
      win_idx          = LW'(onehot_to_idx(win_w));
   end

   // Reset drops the bus side in the same cycle, not just on the next edge.
   assign own  = (state == OWN) && !wb_rst;
   assign busy = (state == OWN);

`ifdef DBUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] to_cnt;

   // Down-counter loaded on grant; terminal count means TIMEOUT OWN cycles elapsed.
   assign to_hit = own && (to_cnt == '0) && !s_ack && m_cyc[g_idx];
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      s_cyc = 1'b0;
      s_we  = 1'b0;
      s_adr = '0;
      s_dat = '0;
      s_sel = '0;
      m_ack = '0;
      m_rdt = '0;
      if (own) begin
         s_cyc = m_cyc[g_idx] && !to_hit;
         s_we  = m_we[g_idx];
         s_adr = m_adr[int'(g_idx)*AW +: AW];
         s_dat = m_dat[int'(g_idx)*32 +: 32];
         s_sel = m_sel[int'(g_idx)*4 +: 4];
         if (s_ack || to_hit) begin
            m_ack[g_idx]                 = 1'b1;
            m_rdt[int'(g_idx)*32 +: 32]  = to_hit ? DBUS_ERR_DATA : s_rdt;
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state   <= IDLE;
         grant   <= '0;
         last    <= LW'(N - 1);
`ifdef DBUS_ARB_TIMEOUT_EN
         to_cnt  <= '0;
         timeout <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  grant  <= win;
                  last   <= win_idx;
                  state  <= OWN;
`ifdef DBUS_ARB_TIMEOUT_EN
                  to_cnt <= CW'(TIMEOUT);
`endif
               end
            end
            OWN: begin
               if (s_ack || to_hit) begin
                  state <= TURN;
                  grant <= '0;
`ifdef DBUS_ARB_TIMEOUT_EN
                  if (to_hit) timeout <= 1'b1;
`endif
               end else if (!m_cyc[g_idx]) begin
                  state <= IDLE;
                  grant <= '0;
               end
`ifdef DBUS_ARB_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt - CW'(1);
               end
`endif
            end
            TURN:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
